sfr_master: RTL and testbench

SFR_MASTER -- requirements
Module: sfr_master

---
 rtl/sfr_master.sv | 158 +++++++++++++++
 tb/tb_sfr_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sfr_master.sv
// Command/response bridge onto a simple SFR bus (address, write_data, we, re, read_data).
// Define SFR_MASTER_WRITE_VERIFY_EN to read back and compare every write.
module sfr_master #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  we,
  output logic                  re,
  input  logic [DATA_WIDTH-1:0] read_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_READ   = 3'd2,
    S_VERIFY = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  // Counter reload: re is held for cnt_q+1 cycles.
  localparam logic [3:0] LAT_LAST = 4'(READ_LATENCY - 1);

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  cmd_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_write_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [ADDR_WIDTH-1:0] address_q;
  logic [DATA_WIDTH-1:0] write_data_q;
  logic                  we_q;
  logic                  re_q;
`ifdef SFR_MASTER_WRITE_VERIFY_EN
  logic                  rsp_error_q;
`endif

  // Transaction FSM with all bus and response outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_write_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
`ifdef SFR_MASTER_WRITE_VERIFY_EN
      rsp_error_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q  <= 1'b0;
            address_q    <= cmd_addr;
            write_data_q <= cmd_wdata;
            rsp_write_q  <= cmd_write;
            if (cmd_write) begin
              state_q <= S_WRITE;
              we_q    <= 1'b1;
            end else begin
              state_q <= S_READ;
              re_q    <= 1'b1;
              cnt_q   <= LAT_LAST;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        S_WRITE: begin
          we_q <= 1'b0;
`ifdef SFR_MASTER_WRITE_VERIFY_EN
          state_q <= S_VERIFY;
          re_q    <= 1'b1;
          cnt_q   <= LAT_LAST;
`else
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= '0;
`endif
        end
        S_READ: begin
          if (cnt_q == 4'd0) begin
            re_q        <= 1'b0;
            rsp_rdata_q <= read_data;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`ifdef SFR_MASTER_WRITE_VERIFY_EN
        S_VERIFY: begin
          if (cnt_q == 4'd0) begin
            re_q        <= 1'b0;
            rsp_rdata_q <= read_data;
            rsp_error_q <= (read_data != write_data_q);
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`endif
        S_RESP: begin
          // Ready is raised on retirement, so the next acceptance is one edge later.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            rsp_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          we_q        <= 1'b0;
          re_q        <= 1'b0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign address    = address_q;
  assign write_data = write_data_q;
  assign we         = we_q;
  assign re         = re_q;
`ifdef SFR_MASTER_WRITE_VERIFY_EN
  assign rsp_error  = rsp_error_q;
`else
  assign rsp_error  = 1'b0;
`endif

endmodule

// File: tb/tb_sfr_master.sv
// Directed self-checking bench for sfr_master (READ_LATENCY=3) with a small SFR memory responder.
module tb_sfr_master;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_write;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic [7:0] address;
  logic [7:0] write_data;
  logic       we;
  logic       re;
  logic [7:0] read_data;
  logic       force_bad;
  logic [7:0] mem [256];

  int n_tests;
  int n_fail;
  int n_accept;
  int n_overlap;

`ifdef SFR_MASTER_WRITE_VERIFY_EN
  localparam int WR_LAT = 5;
`else
  localparam int WR_LAT = 2;
`endif

  sfr_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(3)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .address(address), .write_data(write_data), .we(we), .re(re),
    .read_data(read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: registered writes, combinational reads, optional bit-0 corruption.
  always @(posedge clk) if (we) mem[address] <= write_data;
  assign read_data = mem[address] ^ {7'd0, force_bad};

  initial begin
    n_accept  = 0;
    n_overlap = 0;
  end
  always @(posedge clk) if (!reset && cmd_valid && cmd_ready) n_accept <= n_accept + 1;
  always @(negedge clk) if (we && re) n_overlap <= n_overlap + 1;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic w, input logic [7:0] a, input logic [7:0] d, output int lat);
    int guard;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    guard = 0;
    while (!cmd_ready && guard < 20) begin tick(); guard++; end
    check("accept_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin tick(); lat++; end
    check("rsp_arrives", {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    int lat;
    int k;
    int guard;
    int acc0;
    logic [7:0] rd_seen;
    logic       bv_w [3];
    logic [7:0] bv_a [3];
    logic [7:0] bv_d [3];
    n_tests = 0; n_fail = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00;
    cmd_wdata = 8'h00; rsp_ready = 1'b0; force_bad = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_we_re", {30'd0, we, re}, 32'd0);
    check("rst_address", {24'd0, address}, 32'd0);
    check("rst_wdata", {24'd0, write_data}, 32'd0);
    check("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    reset = 1'b0;
    tick();
    check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // Write 0x10 <- 0xA5
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 8'hA5; rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("wr_we", {31'd0, we}, 32'd1);
    check("wr_re", {31'd0, re}, 32'd0);
    check("wr_address", {24'd0, address}, 32'h10);
    check("wr_wdata", {24'd0, write_data}, 32'hA5);
    check("wr_not_ready", {31'd0, cmd_ready}, 32'd0);
`ifdef SFR_MASTER_WRITE_VERIFY_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      check("vfy_re", {31'd0, re}, 32'd1);
      check("vfy_we", {31'd0, we}, 32'd0);
      check("vfy_address", {24'd0, address}, 32'h10);
    end
`endif
    tick();
    check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("wr_rsp_write", {31'd0, rsp_write}, 32'd1);
    check("wr_rsp_we_off", {30'd0, we, re}, 32'd0);
    check("wr_rsp_error", {31'd0, rsp_error}, 32'd0);
`ifdef SFR_MASTER_WRITE_VERIFY_EN
    check("wr_rsp_rdata", {24'd0, rsp_rdata}, 32'hA5);
`else
    check("wr_rsp_rdata", {24'd0, rsp_rdata}, 32'h00);
`endif
    tick();
    check("wr_retired", {31'd0, rsp_valid}, 32'd0);
    check("wr_idle_ready", {31'd0, cmd_ready}, 32'd1);

    // Read 0x10 with a stalled response
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rd_re", {31'd0, re}, 32'd1);
      check("rd_we", {31'd0, we}, 32'd0);
      tick();
    end
    check("rd_re_done", {31'd0, re}, 32'd0);
    check("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd_rdata", {24'd0, rsp_rdata}, 32'hA5);
    check("rd_rsp_write", {31'd0, rsp_write}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", {24'd0, rsp_rdata}, 32'hA5);
      check("hold_not_ready", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check("hold_retired", {31'd0, rsp_valid}, 32'd0);
    check("hold_idle", {31'd0, cmd_ready}, 32'd1);

    // Reset during the second READ cycle
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("pre_reset_re", {31'd0, re}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_we_re", {30'd0, we, re}, 32'd0);
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (4) tick();
    check("no_orphan_rsp", {31'd0, rsp_valid}, 32'd0);

    // Top-of-range address, driven unmodified
    run_cmd(1'b1, 8'hFF, 8'h5A, lat);
    check("wr_latency", lat, WR_LAT);
    check("ff_address", {24'd0, address}, 32'hFF);
    check("ff_wdata", {24'd0, write_data}, 32'h5A);
    run_cmd(1'b0, 8'hFF, 8'h00, lat);
    check("rd_latency", lat, 32'd4);
    check("ff_rdata", {24'd0, rsp_rdata}, 32'h5A);
    check("ff_rsp_write", {31'd0, rsp_write}, 32'd0);
    check("ff_address_hold", {24'd0, address}, 32'hFF);
    tick();

`ifdef SFR_MASTER_WRITE_VERIFY_EN
    force_bad = 1'b1;
    run_cmd(1'b1, 8'h20, 8'h3C, lat);
    check("vfy_bad_error", {31'd0, rsp_error}, 32'd1);
    check("vfy_bad_rdata", {24'd0, rsp_rdata}, 32'h3D);
    force_bad = 1'b0;
    tick();
    run_cmd(1'b1, 8'h20, 8'h3C, lat);
    check("vfy_ok_error", {31'd0, rsp_error}, 32'd0);
    check("vfy_ok_rdata", {24'd0, rsp_rdata}, 32'h3C);
`endif

    // Back-to-back commands with cmd_valid held high
    bv_w[0] = 1'b1; bv_a[0] = 8'h30; bv_d[0] = 8'h11;
    bv_w[1] = 1'b0; bv_a[1] = 8'h30; bv_d[1] = 8'h00;
    bv_w[2] = 1'b1; bv_a[2] = 8'h31; bv_d[2] = 8'h22;
    acc0 = n_accept;
    rd_seen = 8'h00;
    k = 0; guard = 0;
    cmd_valid = 1'b1; cmd_write = bv_w[0]; cmd_addr = bv_a[0]; cmd_wdata = bv_d[0];
    while (k < 3 && guard < 80) begin
      if (rsp_valid && !rsp_write) rd_seen = rsp_rdata;
      if (cmd_ready) begin
        tick();
        k++;
        if (k < 3) begin
          cmd_write = bv_w[k]; cmd_addr = bv_a[k]; cmd_wdata = bv_d[k];
        end else begin
          cmd_valid = 1'b0;
        end
      end else begin
        tick();
      end
      guard++;
    end
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid && !rsp_write) rd_seen = rsp_rdata;
      tick();
    end
    check("b2b_accepts", n_accept - acc0, 32'd3);
    check("b2b_read", {24'd0, rd_seen}, 32'h11);
    check("b2b_mem30", {24'd0, mem[8'h30]}, 32'h11);
    check("b2b_mem31", {24'd0, mem[8'h31]}, 32'h22);
    check("we_re_overlap", n_overlap, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
